// File: rtl/regfile_pkg.sv
// Shared types and sizing helpers for the multi-port integer register file.
// Imported by decode, writeback and the register file itself.
package regfile_pkg;

  localparam int XLEN_D  = 32;
  localparam int NREGS_D = 32;

  function automatic int aw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int AW_D = aw(NREGS_D);

  typedef logic [XLEN_D-1:0] rf_data_t;
  typedef logic [AW_D-1:0]   rf_addr_t;

endpackage

// File: rtl/regfile_mp_if.sv
// Decode/writeback bundle for regfile_mp: read, write and allocate ports.
// master = pipeline side, slave = register file.
interface regfile_mp_if
  import regfile_pkg::*;
#(
  parameter int XLEN  = XLEN_D,
  parameter int NREGS = NREGS_D,
  parameter int NRD   = 2,
  parameter int NWR   = 1
);
  localparam int AW = aw(NREGS);

  logic [NRD-1:0][AW-1:0]   ra;
  logic [NRD-1:0][XLEN-1:0] rd;
  logic [NRD-1:0]           rd_busy;
  logic [NWR-1:0]           we;
  logic [NWR-1:0][AW-1:0]   wa;
  logic [NWR-1:0][XLEN-1:0] wd;
  logic                     alloc_en;
  logic [AW-1:0]            alloc_a;

  modport master (
    output ra, we, wa, wd,
    output alloc_en, alloc_a,
    input  rd, rd_busy
  );

  modport slave (
    input  ra, we, wa, wd,
    input  alloc_en, alloc_a,
    output rd, rd_busy
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: set by allocate, cleared by writeback,
// with a combinational busy lookup per read port.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS    = NREGS_D,
  parameter int NRD      = 2,
  parameter int NWR      = 1,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1,
  localparam int AW      = aw(NREGS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NRD-1:0][AW-1:0] ra_i,
  input  logic [NWR-1:0]         we_i,
  input  logic [NWR-1:0][AW-1:0] wa_i,
  input  logic                   alloc_en_i,
  input  logic [AW-1:0]          alloc_a_i,
  output logic [NRD-1:0]         rd_busy_o
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  logic [NREGS-1:0] set_v;
  logic [NREGS-1:0] clr_v;

  // set wins over clear: a fresh producer overrides the retiring one
  always_comb begin
    set_v  = '0;
    clr_v  = '0;
    busy_d = '0;
    for (int r = 0; r < NREGS; r++) begin
      set_v[r] = alloc_en_i && (alloc_a_i == AW'(r));
      for (int i = 0; i < NWR; i++) begin
        if (we_i[i] && (wa_i[i] == AW'(r))) begin
          clr_v[r] = 1'b1;
        end
      end
      if (ZERO_REG != 0 && r == 0) begin
        set_v[r] = 1'b0;
        clr_v[r] = 1'b0;
      end
      busy_d[r] = set_v[r] | (busy_q[r] & ~clr_v[r]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  always_comb begin
    rd_busy_o = '0;
    for (int j = 0; j < NRD; j++) begin
      rd_busy_o[j] = busy_q[ra_i[j]];
      if (BYPASS != 0 && clr_v[ra_i[j]] && !set_v[ra_i[j]]) begin
        rd_busy_o[j] = 1'b0;
      end
      if (ZERO_REG != 0 && ra_i[j] == '0) begin
        rd_busy_o[j] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port RV32I register file with optional
// write-to-read bypass, hardwired x0 and a busy scoreboard.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN     = XLEN_D,
  parameter int NREGS    = NREGS_D,
  parameter int NRD      = 2,
  parameter int NWR      = 1,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  regfile_mp_if.slave  rf_bus
);

  localparam int AW = aw(NREGS);

  logic [XLEN-1:0]  rf_q   [NREGS];
  logic [XLEN-1:0]  rf_d   [NREGS];
  logic [XLEN-1:0]  wr_dat [NREGS];
  logic [NREGS-1:0] wr_hit;

  // later ports overwrite earlier ones, so the highest index wins
  function automatic logic [XLEN:0] wr_pick(
    input logic [NWR-1:0]           we,
    input logic [NWR-1:0][AW-1:0]   wa,
    input logic [NWR-1:0][XLEN-1:0] wd,
    input logic [AW-1:0]            a
  );
    logic [XLEN:0] res;
    res = '0;
    for (int i = 0; i < NWR; i++) begin
      if (we[i] && (wa[i] == a)) begin
        res = {1'b1, wd[i]};
      end
    end
    return res;
  endfunction

  always_comb begin
    wr_hit = '0;
    for (int r = 0; r < NREGS; r++) begin
      {wr_hit[r], wr_dat[r]} =
        wr_pick(rf_bus.we, rf_bus.wa, rf_bus.wd, AW'(r));
      if (ZERO_REG != 0 && r == 0) begin
        wr_hit[r] = 1'b0;
      end
      rf_d[r] = wr_hit[r] ? wr_dat[r] : rf_q[r];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) begin
        rf_q[r] <= '0;
      end
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        rf_q[r] <= rf_d[r];
      end
    end
  end

  // bypass is suppressed in reset so rd reads zero from assertion on
  always_comb begin
    rf_bus.rd = '0;
    for (int j = 0; j < NRD; j++) begin
      rf_bus.rd[j] = rf_q[rf_bus.ra[j]];
      if (BYPASS != 0 && rst_n && wr_hit[rf_bus.ra[j]]) begin
        rf_bus.rd[j] = wr_dat[rf_bus.ra[j]];
      end
      if (ZERO_REG != 0 && rf_bus.ra[j] == '0) begin
        rf_bus.rd[j] = '0;
      end
    end
  end

  regfile_scoreboard #(
    .NREGS    (NREGS),
    .NRD      (NRD),
    .NWR      (NWR),
    .BYPASS   (BYPASS),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .ra_i       (rf_bus.ra),
    .we_i       (rf_bus.we),
    .wa_i       (rf_bus.wa),
    .alloc_en_i (rf_bus.alloc_en),
    .alloc_a_i  (rf_bus.alloc_a),
    .rd_busy_o  (rf_bus.rd_busy)
  );

endmodule
